// File: rtl/spad_instr_dispatch.sv
// Scratchpad instruction dispatcher: in-order FIFO intake, opcode decode, and
// hazard-scoreboarded issue to the load/store and GEMM request ports.
module spad_instr_dispatch #(
  parameter int DEPTH  = 8,
  parameter int MAT_W  = 6,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      instr_wen,
  input  logic [1:0]                instr_opcode,
  input  logic [MAT_W-1:0]          instr_mat,
  input  logic [ADDR_W-1:0]         instr_addr,
  output logic                      instr_full,
  output logic [$clog2(DEPTH):0]    instr_count,
  output logic                      overflow,
  output logic                      ls_req_valid,
  input  logic                      ls_req_ready,
  output logic                      ls_req_store,
  output logic [MAT_W-1:0]          ls_req_mat,
  output logic [ADDR_W-1:0]         ls_req_addr,
  input  logic                      ls_done,
  input  logic [MAT_W-1:0]          ls_done_mat,
  output logic                      gemm_req_valid,
  input  logic                      gemm_req_ready,
  output logic [MAT_W-1:0]          gemm_rd,
  output logic [MAT_W-1:0]          gemm_rs_in,
  output logic [MAT_W-1:0]          gemm_rs_wt,
  output logic [MAT_W-1:0]          gemm_rs_ps,
  output logic                      gemm_new_weight,
  input  logic                      gemm_done,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      idle
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int NMAT   = 2 ** MAT_W;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_GEMM  = 2'd3
  } op_e;

  logic [1:0]        op_mem   [DEPTH];
  logic [MAT_W-1:0]  mat_mem  [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              ls_valid_q, ls_valid_d;
  logic              ls_store_q, ls_store_d;
  logic [MAT_W-1:0]  ls_mat_q, ls_mat_d;
  logic [ADDR_W-1:0] ls_addr_q, ls_addr_d;

  logic              gemm_valid_q, gemm_valid_d;
  logic [MAT_W-1:0]  gemm_rd_q, gemm_rd_d;
  logic [MAT_W-1:0]  gemm_in_q, gemm_in_d;
  logic [MAT_W-1:0]  gemm_wt_q, gemm_wt_d;
  logic [MAT_W-1:0]  gemm_ps_q, gemm_ps_d;
  logic              gemm_nw_q, gemm_nw_d;

  logic [NMAT-1:0]   busy_q, busy_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              full;
  logic              head_valid;
  op_e               head_op;
  logic [MAT_W-1:0]  head_mat;
  logic [ADDR_W-1:0] head_addr;
  logic [MAT_W-1:0]  h_rd, h_in, h_wt, h_ps;
  logic              hazard;
  logic              unit_free;
  logic              ls_xfer, gemm_xfer;
  logic              pop, push;
  logic              issue_ls, issue_gemm;

  assign full       = (count_q == FULL_CNT);
  assign head_valid = (count_q != '0);
  assign head_op    = op_e'(op_mem[rd_ptr_q]);
  assign head_mat   = mat_mem[rd_ptr_q];
  assign head_addr  = addr_mem[rd_ptr_q];

  // GEMM operand fields packed into the address word, rs_ps at the LSBs
  assign h_ps = head_addr[MAT_W-1:0];
  assign h_wt = head_addr[2*MAT_W-1:MAT_W];
  assign h_in = head_addr[3*MAT_W-1:2*MAT_W];
  assign h_rd = head_addr[4*MAT_W-1:3*MAT_W];

  assign ls_xfer   = ls_valid_q && ls_req_ready;
  assign gemm_xfer = gemm_valid_q && gemm_req_ready;

  // The in-flight GEMM's sources are held in the GEMM payload register,
  // which cannot reload until that GEMM has drained.
  always_comb begin
    hazard    = 1'b0;
    unit_free = 1'b1;
    case (head_op)
      OP_LOAD: begin
        hazard    = busy_q[head_mat] ||
                    (inflight_q && ((head_mat == gemm_in_q) ||
                                    (head_mat == gemm_wt_q) ||
                                    (head_mat == gemm_ps_q)));
        unit_free = !ls_valid_q || ls_req_ready;
      end
      OP_STORE: begin
        hazard    = busy_q[head_mat];
        unit_free = !ls_valid_q || ls_req_ready;
      end
      OP_GEMM: begin
        hazard    = inflight_q || busy_q[h_rd] || busy_q[h_in] ||
                    busy_q[h_wt] || busy_q[h_ps];
        unit_free = !gemm_valid_q || gemm_req_ready;
      end
      default: begin
        hazard    = 1'b0;
        unit_free = 1'b1;
      end
    endcase
  end

  assign pop        = head_valid && !hazard && unit_free;
  assign issue_ls   = pop && ((head_op == OP_LOAD) || (head_op == OP_STORE));
  assign issue_gemm = pop && (head_op == OP_GEMM);
  assign push       = instr_wen && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + OCC_W'(1);
    else if (pop && !push) count_d = count_q - OCC_W'(1);
    if (instr_wen && !push) overflow_d = 1'b1;
  end

  always_comb begin
    ls_valid_d   = ls_valid_q;
    ls_store_d   = ls_store_q;
    ls_mat_d     = ls_mat_q;
    ls_addr_d    = ls_addr_q;
    gemm_valid_d = gemm_valid_q;
    gemm_rd_d    = gemm_rd_q;
    gemm_in_d    = gemm_in_q;
    gemm_wt_d    = gemm_wt_q;
    gemm_ps_d    = gemm_ps_q;
    gemm_nw_d    = gemm_nw_q;
    if (ls_xfer) ls_valid_d = 1'b0;
    if (issue_ls) begin
      ls_valid_d = 1'b1;
      ls_store_d = (head_op == OP_STORE);
      ls_mat_d   = head_mat;
      ls_addr_d  = head_addr;
    end
    if (gemm_xfer) gemm_valid_d = 1'b0;
    if (issue_gemm) begin
      gemm_valid_d = 1'b1;
      gemm_rd_d    = h_rd;
      gemm_in_d    = h_in;
      gemm_wt_d    = h_wt;
      gemm_ps_d    = h_ps;
      gemm_nw_d    = head_mat[MAT_W-1];
    end
  end

  // Clears are applied before sets so a same-cycle issue keeps its bit.
  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    stall_d    = stall_q;
    if (ls_done) busy_d[ls_done_mat] = 1'b0;
    if (gemm_done && inflight_q) begin
      busy_d[gemm_rd_q] = 1'b0;
      inflight_d        = 1'b0;
    end
    if (issue_ls && (head_op == OP_LOAD)) busy_d[head_mat] = 1'b1;
    if (issue_gemm) begin
      busy_d[h_rd] = 1'b1;
      inflight_d   = 1'b1;
    end
    if (head_valid && (head_op != OP_NOP) && hazard && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= instr_opcode;
      mat_mem[wr_ptr_q]  <= instr_mat;
      addr_mem[wr_ptr_q] <= instr_addr;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      ls_valid_q   <= 1'b0;
      ls_store_q   <= 1'b0;
      ls_mat_q     <= '0;
      ls_addr_q    <= '0;
      gemm_valid_q <= 1'b0;
      gemm_rd_q    <= '0;
      gemm_in_q    <= '0;
      gemm_wt_q    <= '0;
      gemm_ps_q    <= '0;
      gemm_nw_q    <= 1'b0;
      busy_q       <= '0;
      inflight_q   <= 1'b0;
      stall_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      ls_valid_q   <= ls_valid_d;
      ls_store_q   <= ls_store_d;
      ls_mat_q     <= ls_mat_d;
      ls_addr_q    <= ls_addr_d;
      gemm_valid_q <= gemm_valid_d;
      gemm_rd_q    <= gemm_rd_d;
      gemm_in_q    <= gemm_in_d;
      gemm_wt_q    <= gemm_wt_d;
      gemm_ps_q    <= gemm_ps_d;
      gemm_nw_q    <= gemm_nw_d;
      busy_q       <= busy_d;
      inflight_q   <= inflight_d;
      stall_q      <= stall_d;
    end
  end

  assign instr_full      = full;
  assign instr_count     = count_q;
  assign overflow        = overflow_q;
  assign ls_req_valid    = ls_valid_q;
  assign ls_req_store    = ls_store_q;
  assign ls_req_mat      = ls_mat_q;
  assign ls_req_addr     = ls_addr_q;
  assign gemm_req_valid  = gemm_valid_q;
  assign gemm_rd         = gemm_rd_q;
  assign gemm_rs_in      = gemm_in_q;
  assign gemm_rs_wt      = gemm_wt_q;
  assign gemm_rs_ps      = gemm_ps_q;
  assign gemm_new_weight = gemm_nw_q;
  assign stall_cycles    = stall_q;
  assign idle            = !head_valid && !ls_valid_q && !gemm_valid_q &&
                           (busy_q == '0) && !inflight_q;

endmodule

// File: tb/tb_spad_instr_dispatch.sv
// Scoreboard bench for spad_instr_dispatch: ordering, hazard stalls,
// issue latency, overflow and asynchronous reset.
`timescale 1ns/1ps
module tb_spad_instr_dispatch;

  localparam int DEPTH = 8, MAT_W = 6, ADDR_W = 32, CNT_W = 16;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              instr_wen = 1'b0;
  logic [1:0]        instr_opcode = '0;
  logic [MAT_W-1:0]  instr_mat = '0;
  logic [ADDR_W-1:0] instr_addr = '0;
  logic              instr_full;
  logic [3:0]        instr_count;
  logic              overflow;
  logic              ls_req_valid, ls_req_ready = 1'b1, ls_req_store;
  logic [MAT_W-1:0]  ls_req_mat;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_done = 1'b0;
  logic [MAT_W-1:0]  ls_done_mat = '0;
  logic              gemm_req_valid, gemm_req_ready = 1'b1;
  logic [MAT_W-1:0]  gemm_rd, gemm_rs_in, gemm_rs_wt, gemm_rs_ps;
  logic              gemm_new_weight;
  logic              gemm_done = 1'b0;
  logic [CNT_W-1:0]  stall_cycles;
  logic              idle;

  spad_instr_dispatch #(.DEPTH(DEPTH), .MAT_W(MAT_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .instr_wen(instr_wen), .instr_opcode(instr_opcode), .instr_mat(instr_mat),
    .instr_addr(instr_addr), .instr_full(instr_full), .instr_count(instr_count),
    .overflow(overflow),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_store(ls_req_store),
    .ls_req_mat(ls_req_mat), .ls_req_addr(ls_req_addr),
    .ls_done(ls_done), .ls_done_mat(ls_done_mat),
    .gemm_req_valid(gemm_req_valid), .gemm_req_ready(gemm_req_ready),
    .gemm_rd(gemm_rd), .gemm_rs_in(gemm_rs_in), .gemm_rs_wt(gemm_rs_wt),
    .gemm_rs_ps(gemm_rs_ps), .gemm_new_weight(gemm_new_weight),
    .gemm_done(gemm_done), .stall_cycles(stall_cycles), .idle(idle)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic st; logic [MAT_W-1:0] mat; logic [ADDR_W-1:0] addr; } ls_t;
  typedef struct { logic [MAT_W-1:0] rd, rin, wt, ps; logic nw; } gm_t;
  ls_t ls_exp[$];
  gm_t gm_exp[$];
  int  ls_cyc[$];
  int  gm_cyc[$];
  ls_t le;
  gm_t ge;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (ls_req_valid && ls_req_ready) begin
        ls_cyc.push_back(cyc);
        if (ls_exp.size() == 0) check_val("ls_unexpected", 1, 0);
        else begin
          le = ls_exp.pop_front();
          check_val("ls_store", ls_req_store, le.st);
          check_val("ls_mat", ls_req_mat, le.mat);
          check_val("ls_addr", ls_req_addr, le.addr);
        end
      end
      if (gemm_req_valid && gemm_req_ready) begin
        gm_cyc.push_back(cyc);
        if (gm_exp.size() == 0) check_val("gemm_unexpected", 1, 0);
        else begin
          ge = gm_exp.pop_front();
          check_val("gemm_rd", gemm_rd, ge.rd);
          check_val("gemm_in", gemm_rs_in, ge.rin);
          check_val("gemm_wt", gemm_rs_wt, ge.wt);
          check_val("gemm_ps", gemm_rs_ps, ge.ps);
          check_val("gemm_nw", gemm_new_weight, ge.nw);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic push(input logic [1:0] op, input logic [MAT_W-1:0] m, input logic [ADDR_W-1:0] a);
    instr_wen = 1'b1; instr_opcode = op; instr_mat = m; instr_addr = a;
    tick();
    instr_wen = 1'b0;
  endtask

  task automatic push_ls(input logic st, input logic [MAT_W-1:0] m, input logic [ADDR_W-1:0] a);
    ls_exp.push_back('{st: st, mat: m, addr: a});
    push(st ? 2'd2 : 2'd1, m, a);
  endtask

  task automatic push_gemm(input logic [MAT_W-1:0] rd, rin, wt, ps, input logic nw);
    gm_exp.push_back('{rd: rd, rin: rin, wt: wt, ps: ps, nw: nw});
    push(2'd3, {nw, {(MAT_W-1){1'b0}}}, {8'h00, rd, rin, wt, ps});
  endtask

  task automatic pulse_ls_done(input logic [MAT_W-1:0] m);
    ls_done = 1'b1; ls_done_mat = m;
    tick();
    ls_done = 1'b0;
  endtask

  task automatic pulse_gemm_done();
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int n0, t, t2, t3;

  initial begin
    tick(2);
    nRST = 1'b1;
    tick();
    check_val("rst_idle", idle, 1);
    check_val("rst_ls_valid", ls_req_valid, 0);
    check_val("rst_gemm_valid", gemm_req_valid, 0);
    check_val("rst_count", instr_count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_stall", stall_cycles, 0);
    check_val("rst_ls_addr", ls_req_addr, 0);
    check_val("rst_gemm_rd", gemm_rd, 0);

    // NOP is consumed without generating a request
    push(2'd0, 6'h11, 32'h1234);
    tick(2);
    check_val("nop_count", instr_count, 0);
    check_val("nop_idle", idle, 1);
    check_val("nop_no_req", ls_cyc.size(), 0);

    // back-to-back loads
    n0 = cyc;
    push_ls(1'b0, 6'h25, 32'd4);
    push_ls(1'b0, 6'h15, 32'd36);
    push_ls(1'b0, 6'h05, 32'd68);
    tick(4);
    check_val("load_xfers", ls_cyc.size(), 3);
    for (int i = 0; i < 3; i++) check_val("load_cycle", ls_cyc[i], n0 + 2 + i);
    check_val("load_busy_not_idle", idle, 0);
    pulse_ls_done(6'h25);
    pulse_ls_done(6'h15);

    // GEMM stalled on RAW against 0x05, STORE of its result queued behind
    n0 = cyc;
    push_gemm(6'h35, 6'h15, 6'h25, 6'h05, 1'b1);
    push_ls(1'b1, 6'h35, 32'd100);
    tick(3);
    check_val("gemm_stalled", gemm_req_valid, 0);
    check_val("gemm_stall_no_xfer", gm_cyc.size(), 0);
    t = cyc;
    pulse_ls_done(6'h05);
    check_val("gemm_stall_count", stall_cycles, t - n0);
    check_val("gemm_not_yet", gemm_req_valid, 0);
    tick();
    check_val("gemm_valid_t2", gemm_req_valid, 1);
    tick(2);
    check_val("gemm_xfers", gm_cyc.size(), 1);
    if (gm_cyc.size() > 0) check_val("gemm_cycle", gm_cyc[0], t + 2);

    // STORE waits for gemm_done; loads queue in order behind it
    push_ls(1'b0, 6'h25, 32'h200);
    push_ls(1'b0, 6'h07, 32'h300);
    tick(4);
    check_val("store_held", ls_cyc.size(), 3);
    t2 = cyc;
    pulse_gemm_done();
    tick(5);
    check_val("post_gemm_xfers", ls_cyc.size(), 6);
    if (ls_cyc.size() >= 6) begin
      check_val("store_cycle", ls_cyc[3], t2 + 2);
      check_val("load25_cycle", ls_cyc[4], t2 + 3);
      check_val("load07_cycle", ls_cyc[5], t2 + 4);
    end

    // WAR: LOAD into a source of the in-flight GEMM waits for gemm_done
    pulse_ls_done(6'h25);
    pulse_ls_done(6'h07);
    push_gemm(6'h10, 6'h07, 6'h25, 6'h15, 1'b0);
    tick(3);
    check_val("gemm2_xfers", gm_cyc.size(), 2);
    push_ls(1'b0, 6'h07, 32'h400);
    tick(4);
    check_val("war_held", ls_cyc.size(), 6);
    t3 = cyc;
    pulse_gemm_done();
    tick(3);
    check_val("war_xfers", ls_cyc.size(), 7);
    if (ls_cyc.size() >= 7) check_val("war_cycle", ls_cyc[6], t3 + 2);
    pulse_ls_done(6'h07);
    check_val("drained_idle", idle, 1);
    check_val("ls_sb_empty", ls_exp.size(), 0);
    check_val("gemm_sb_empty", gm_exp.size(), 0);

    // overflow: head blocked by WAW on matrix 1, ready low
    push_ls(1'b0, 6'h01, 32'h10);
    tick(3);
    check_val("ovf_first_xfer", ls_cyc.size(), 8);
    ls_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(2'd1, 6'h01, 32'h20 + i);
    check_val("ovf_count8", instr_count, 8);
    check_val("ovf_full", instr_full, 1);
    check_val("ovf_not_yet", overflow, 0);
    push(2'd1, 6'h01, 32'h99);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_count_kept", instr_count, 8);
    check_val("ovf_full_kept", instr_full, 1);
    pulse_ls_done(6'h01);
    tick();
    check_val("held_valid", ls_req_valid, 1);
    check_val("held_count", instr_count, 7);
    tick(2);
    check_val("still_stalling", stall_cycles > 0, 1);

    // asynchronous reset mid-stall
    #2 nRST = 1'b0;
    #1;
    check_val("arst_ls_valid", ls_req_valid, 0);
    check_val("arst_count", instr_count, 0);
    check_val("arst_idle", idle, 1);
    check_val("arst_stall", stall_cycles, 0);
    check_val("arst_overflow", overflow, 0);
    ls_exp.delete();
    #4 nRST = 1'b1;
    ls_req_ready = 1'b1;
    tick(2);
    check_val("arst_after_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
